// File: rtl/life_step_engine.sv
`default_nettype none
// ============================================================================
//  Module      : life_step_engine
//  Description : Computes one Conway's Life generation over a COLS x ROWS
//                single-bit cell grid. The current generation is read from a
//                source grid RAM with a 1-cycle registered read port. The next
//                generation is written to a destination grid RAM, one cell
//                per 11 cycles: 9 neighbour fetches, 1 drain and 1 write.
//                One start pulse accepted in IDLE produces one generation.
//
//  Ports       : clk_74a     in   sole clock, rising edge
//                reset       in   synchronous, active-high
//                start       in   request one generation (IDLE only)
//                busy        out  high while a generation is in progress
//                done        out  one-cycle pulse after the final cell write
//                gen_count   out  completed generations since reset (wraps)
//                src_addr    out  source RAM read address
//                src_rd_data in   source RAM data, valid one cycle after addr
//                dst_wr_en   out  destination RAM write strobe
//                dst_addr    out  destination RAM write address
//                dst_data    out  next-generation cell value
//
//  Build option: LIFE_WRAP_EN defined   -> toroidal grid
//                LIFE_WRAP_EN undefined -> dead border; out-of-range
//                neighbour slots present the centre address and are masked
//
//  Revision    : 1.0  initial release
// ============================================================================
module life_step_engine #(
    parameter int COLS       = 40,
    parameter int ROWS       = 30,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk_74a,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           gen_count,
    output logic [ADDR_WIDTH-1:0] src_addr,
    input  logic                  src_rd_data,
    output logic                  dst_wr_en,
    output logic [ADDR_WIDTH-1:0] dst_addr,
    output logic                  dst_data
);

    localparam int c_row_w = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_col_w = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [c_row_w-1:0]    c_last_row = c_row_w'(ROWS - 1);
    localparam logic [c_col_w-1:0]    c_last_col = c_col_w'(COLS - 1);
    localparam logic [ADDR_WIDTH-1:0] c_cols     = ADDR_WIDTH'(COLS);

`ifdef LIFE_WRAP_EN
    localparam logic c_wrap = 1'b1;
`else
    localparam logic c_wrap = 1'b0;
`endif

    // The column/row advance is folded into the WRITE cycle, so no separate
    // ADVANCE encoding is ever entered.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DRAIN  = 3'd2,
        S_WRITE  = 3'd3,
        S_FINISH = 3'd5
    } state_t;

    state_t               r_state;
    logic [c_row_w-1:0]   r_row;
    logic [c_col_w-1:0]   r_col;
    logic [3:0]           r_k;
    logic [3:0]           r_n;
    logic                 r_alive;
    // Slot descriptors travel alongside the read request: r_req_* describe the
    // address presented this cycle, r_rsp_* describe the data returning now.
    logic                 r_req_cnt;
    logic                 r_req_ctr;
    logic                 r_rsp_cnt;
    logic                 r_rsp_ctr;

    logic [c_row_w-1:0]    w_base_row;
    logic [c_col_w-1:0]    w_base_col;
    logic [3:0]            w_slot;
    logic [1:0]            w_dr;
    logic [1:0]            w_dc;
    logic [c_row_w-1:0]    w_nr;
    logic [c_col_w-1:0]    w_nc;
    logic                  w_row_ok;
    logic                  w_col_ok;
    logic                  w_slot_valid;
    logic [ADDR_WIDTH-1:0] w_nbr_addr;
    logic [ADDR_WIDTH-1:0] w_cell_addr;
    logic [c_row_w-1:0]    w_next_row;
    logic [c_col_w-1:0]    w_next_col;
    logic                  w_last_cell;
    logic [3:0]            w_n_final;

    // Next cell position in row-major order
    always_comb begin
        w_last_cell = (r_row == c_last_row) && (r_col == c_last_col);
        if (r_col == c_last_col) begin
            w_next_col = '0;
            w_next_row = r_row + c_row_w'(1);
        end else begin
            w_next_col = r_col + c_col_w'(1);
            w_next_row = r_row;
        end
    end

    // Neighbour address generator. Selects the cell and slot for the address
    // that will be presented in the following cycle.
    always_comb begin
        w_base_row = r_row;
        w_base_col = r_col;
        w_slot     = r_k + 4'd1;
        case (r_state)
            S_IDLE: begin
                w_base_row = '0;
                w_base_col = '0;
                w_slot     = 4'd0;
            end
            S_WRITE: begin
                w_base_row = w_next_row;
                w_base_col = w_next_col;
                w_slot     = 4'd0;
            end
            default: ;
        endcase

        // dr = slot/3 - 1, dc = slot%3 - 1, encoded as 0,1,2 for -1,0,+1
        case (w_slot)
            4'd0:    begin w_dr = 2'd0; w_dc = 2'd0; end
            4'd1:    begin w_dr = 2'd0; w_dc = 2'd1; end
            4'd2:    begin w_dr = 2'd0; w_dc = 2'd2; end
            4'd3:    begin w_dr = 2'd1; w_dc = 2'd0; end
            4'd4:    begin w_dr = 2'd1; w_dc = 2'd1; end
            4'd5:    begin w_dr = 2'd1; w_dc = 2'd2; end
            4'd6:    begin w_dr = 2'd2; w_dc = 2'd0; end
            4'd7:    begin w_dr = 2'd2; w_dc = 2'd1; end
            default: begin w_dr = 2'd2; w_dc = 2'd2; end
        endcase

        w_nr     = w_base_row;
        w_row_ok = 1'b1;
        case (w_dr)
            2'd0: begin
                if (w_base_row == '0) begin
                    w_nr     = c_last_row;
                    w_row_ok = c_wrap;
                end else begin
                    w_nr = w_base_row - c_row_w'(1);
                end
            end
            2'd2: begin
                if (w_base_row == c_last_row) begin
                    w_nr     = '0;
                    w_row_ok = c_wrap;
                end else begin
                    w_nr = w_base_row + c_row_w'(1);
                end
            end
            default: ;
        endcase

        w_nc     = w_base_col;
        w_col_ok = 1'b1;
        case (w_dc)
            2'd0: begin
                if (w_base_col == '0) begin
                    w_nc     = c_last_col;
                    w_col_ok = c_wrap;
                end else begin
                    w_nc = w_base_col - c_col_w'(1);
                end
            end
            2'd2: begin
                if (w_base_col == c_last_col) begin
                    w_nc     = '0;
                    w_col_ok = c_wrap;
                end else begin
                    w_nc = w_base_col + c_col_w'(1);
                end
            end
            default: ;
        endcase

        // Off-grid slots (dead border) read the centre cell; the data is
        // discarded through the slot descriptor.
        w_slot_valid = w_row_ok && w_col_ok;
        if (!w_slot_valid) begin
            w_nr = w_base_row;
            w_nc = w_base_col;
        end

        w_nbr_addr  = ADDR_WIDTH'(w_nr) * c_cols + ADDR_WIDTH'(w_nc);
        w_cell_addr = ADDR_WIDTH'(r_row) * c_cols + ADDR_WIDTH'(r_col);
    end

    // Neighbour total including the slot-8 data that returns during DRAIN
    always_comb begin
        w_n_final = r_n + {3'b000, r_rsp_cnt & src_rd_data};
    end

    always_ff @(posedge clk_74a) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_k       <= 4'd0;
            r_n       <= 4'd0;
            r_alive   <= 1'b0;
            r_req_cnt <= 1'b0;
            r_req_ctr <= 1'b0;
            r_rsp_cnt <= 1'b0;
            r_rsp_ctr <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            gen_count <= 16'd0;
            src_addr  <= '0;
            dst_wr_en <= 1'b0;
            dst_addr  <= '0;
            dst_data  <= 1'b0;
        end else begin
            done      <= 1'b0;
            dst_wr_en <= 1'b0;
            r_rsp_cnt <= r_req_cnt;
            r_rsp_ctr <= r_req_ctr;

            if (r_rsp_cnt && src_rd_data) begin
                r_n <= r_n + 4'd1;
            end
            if (r_rsp_ctr) begin
                r_alive <= src_rd_data;
            end

            case (r_state)
                S_IDLE: begin
                    r_req_cnt <= 1'b0;
                    r_req_ctr <= 1'b0;
                    if (start) begin
                        r_state   <= S_FETCH;
                        r_row     <= '0;
                        r_col     <= '0;
                        r_k       <= 4'd0;
                        r_n       <= 4'd0;
                        busy      <= 1'b1;
                        src_addr  <= w_nbr_addr;
                        r_req_cnt <= w_slot_valid;
                        r_req_ctr <= 1'b0;
                    end
                end

                S_FETCH: begin
                    if (r_k == 4'd8) begin
                        r_state   <= S_DRAIN;
                        r_req_cnt <= 1'b0;
                        r_req_ctr <= 1'b0;
                    end else begin
                        r_k       <= r_k + 4'd1;
                        src_addr  <= w_nbr_addr;
                        r_req_cnt <= w_slot_valid && (w_slot != 4'd4);
                        r_req_ctr <= (w_slot == 4'd4);
                    end
                end

                S_DRAIN: begin
                    r_state   <= S_WRITE;
                    dst_wr_en <= 1'b1;
                    dst_addr  <= w_cell_addr;
                    dst_data  <= (w_n_final == 4'd3) ||
                                 (r_alive && (w_n_final == 4'd2));
                end

                // Write cycle also advances to the next cell
                S_WRITE: begin
                    if (w_last_cell) begin
                        r_state   <= S_FINISH;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        gen_count <= gen_count + 16'd1;
                    end else begin
                        r_state   <= S_FETCH;
                        r_row     <= w_next_row;
                        r_col     <= w_next_col;
                        r_k       <= 4'd0;
                        r_n       <= 4'd0;
                        src_addr  <= w_nbr_addr;
                        r_req_cnt <= w_slot_valid;
                        r_req_ctr <= 1'b0;
                    end
                end

                S_FINISH: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_life_step_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_step_engine
//  Description : Directed self-checking bench for life_step_engine. Models the
//                source RAM (registered read) and destination RAM, runs whole
//                generations on hand-built patterns and compares timing,
//                counters and the resulting grid against hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_life_step_engine;

    localparam int COLS    = 40;
    localparam int ROWS    = 30;
    localparam int AW      = 11;
    localparam int CELLS   = COLS * ROWS;
    localparam int GEN_CYC = CELLS * 11;

    logic          clk_74a = 1'b0;
    logic          reset   = 1'b1;
    logic          start   = 1'b0;
    logic          busy;
    logic          done;
    logic [15:0]   gen_count;
    logic [AW-1:0] src_addr;
    logic          src_q;
    logic          dst_wr_en;
    logic [AW-1:0] dst_addr;
    logic          dst_data;

    logic src_mem [0:2047];
    logic dst_mem [0:2047];
    logic exp_mem [0:CELLS-1];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_74a = ~clk_74a;

    life_step_engine #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_74a     (clk_74a),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .gen_count   (gen_count),
        .src_addr    (src_addr),
        .src_rd_data (src_q),
        .dst_wr_en   (dst_wr_en),
        .dst_addr    (dst_addr),
        .dst_data    (dst_data)
    );

    always @(posedge clk_74a) begin
        src_q <= src_mem[src_addr];
        if (dst_wr_en) begin
            dst_mem[dst_addr] <= dst_data;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_grids();
        for (int i = 0; i < 2048; i++) begin
            src_mem[i] = 1'b0;
            dst_mem[i] = 1'b1;
        end
        for (int i = 0; i < CELLS; i++) begin
            exp_mem[i] = 1'b0;
        end
    endtask

    task automatic set_src(input int r, input int c);
        src_mem[r * COLS + c] = 1'b1;
    endtask

    task automatic set_exp(input int r, input int c);
        exp_mem[r * COLS + c] = 1'b1;
    endtask

    // Runs one generation; optionally pulses start at relative cycle inject_at
    // (cycle 1 is the first cycle after the accepting edge).
    task automatic run_gen(input string tag, input int inject_at, input int exp_gen);
        int cyc, busy_cnt, wr_cnt, first_wr, last_wr, bad, extra_done;
        busy_cnt = 0; wr_cnt = 0; first_wr = 0; last_wr = 0; bad = 0; extra_done = 0;
        @(negedge clk_74a);
        start = 1'b1;
        @(posedge clk_74a);
        #1;
        start = 1'b0;
        check_eq({tag, "_busy_rise"}, 32'(busy), 1);
        cyc = 1;
        while (done !== 1'b1 && cyc <= GEN_CYC + 50) begin
            if (busy) busy_cnt++;
            if (dst_wr_en) begin
                wr_cnt++;
                if (first_wr == 0) first_wr = cyc;
                last_wr = cyc;
            end
            start = (cyc == inject_at);
            @(posedge clk_74a);
            #1;
            cyc++;
        end
        start = 1'b0;
        check_eq({tag, "_done_cycle"}, cyc, GEN_CYC + 1);
        check_eq({tag, "_busy_at_done"}, 32'(busy), 0);
        check_eq({tag, "_busy_cycles"}, busy_cnt, GEN_CYC);
        check_eq({tag, "_writes"}, wr_cnt, CELLS);
        check_eq({tag, "_first_wr"}, first_wr, 11);
        check_eq({tag, "_last_wr"}, last_wr, GEN_CYC);
        check_eq({tag, "_gen_count"}, 32'(gen_count), exp_gen);
        repeat (20) begin
            @(posedge clk_74a);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra_done++;
        end
        check_eq({tag, "_quiet_after"}, extra_done, 0);
        for (int i = 0; i < CELLS; i++) begin
            if (dst_mem[i] !== exp_mem[i]) bad++;
        end
        check_eq({tag, "_grid_bad_cells"}, bad, 0);
    endtask

    task automatic run_abort(input int abort_at);
        int cyc;
        @(negedge clk_74a);
        start = 1'b1;
        @(posedge clk_74a);
        #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < abort_at) begin
            @(posedge clk_74a);
            #1;
            cyc++;
        end
        check_eq("abort_busy_before", 32'(busy), 1);
        reset = 1'b1;
        @(posedge clk_74a);
        #1;
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_wr_en", 32'(dst_wr_en), 0);
        check_eq("abort_gen_count", 32'(gen_count), 0);
        check_eq("abort_done", 32'(done), 0);
        reset = 1'b0;
        repeat (3) @(posedge clk_74a);
        #1;
    endtask

    initial begin
        clear_grids();
        reset = 1'b1;
        repeat (3) @(posedge clk_74a);
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_gen_count", 32'(gen_count), 0);
        check_eq("rst_src_addr", 32'(src_addr), 0);
        check_eq("rst_wr_en", 32'(dst_wr_en), 0);
        check_eq("rst_dst_addr", 32'(dst_addr), 0);
        check_eq("rst_dst_data", 32'(dst_data), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk_74a);

        // All dead, with a stray start pulse mid-run
        clear_grids();
        run_gen("dead", 5000, 1);

        // Horizontal blinker plus block still life in the top-left corner
        clear_grids();
        set_src(10, 9); set_src(10, 10); set_src(10, 11);
        set_src(0, 0);  set_src(0, 1);   set_src(1, 0);  set_src(1, 1);
        set_exp(9, 10); set_exp(10, 10); set_exp(11, 10);
        set_exp(0, 0);  set_exp(0, 1);   set_exp(1, 0);  set_exp(1, 1);
        run_gen("blink_block", 0, 2);

        // Three corners: wraps into a block across all four corners
        clear_grids();
        set_src(29, 39); set_src(29, 0); set_src(0, 39);
`ifdef LIFE_WRAP_EN
        set_exp(0, 0); set_exp(0, 39); set_exp(29, 0); set_exp(29, 39);
`endif
        run_gen("corner", 0, 3);
`ifdef LIFE_WRAP_EN
        check_eq("corner_origin_born", 32'(dst_mem[0]), 1);
`else
        check_eq("corner_origin_dead", 32'(dst_mem[0]), 0);
`endif

        // Reset in the middle of a generation, then a clean restart
        clear_grids();
        set_src(9, 10); set_src(10, 10); set_src(11, 10);
        set_exp(10, 9); set_exp(10, 10); set_exp(10, 11);
        run_abort(7000);
        for (int i = 0; i < 2048; i++) dst_mem[i] = 1'b1;
        run_gen("restart", 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
